// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile
//   Writer end of the writeback hazard path: MEM/WB pipeline register,
//   writeback data mux and the register file write port, plus the two raw
//   combinational read ports that the forwarding logic bypasses.
//
// Ports
//   clk, reset_n        : single clock, synchronous active-low reset
//   stall               : hold MEM/WB contents and suppress the commit
//   flush               : load a bubble into MEM/WB
//   RegWriteIn, MemtoRegIn, WriteRegisterIn, ALUResultIn, MemDataIn
//                       : MEM-stage fields captured into MEM/WB
//   rs, rt              : read addresses
//   RegWrite, WriteRegister, WriteData
//                       : WB-stage signals to the forwarding logic
//   ReadData1, ReadData2: register file reads (combinational)
//   CommitCount         : number of register file writes committed
//
// Build option
//   WB_INTERNAL_BYPASS_EN : when defined, the register file is write-first,
//   so a read of the register being committed returns WriteData.

module wb_stage_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              RegWriteIn,
    input  logic              MemtoRegIn,
    input  logic [ADDR_W-1:0] WriteRegisterIn,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [31:0]       CommitCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              regwrite_q,  regwrite_d;
    logic              memtoreg_q,  memtoreg_d;
    logic [ADDR_W-1:0] wreg_q,      wreg_d;
    logic [DATA_W-1:0] alu_q,       alu_d;
    logic [DATA_W-1:0] memdata_q,   memdata_d;
    logic [31:0]       commit_count_q, commit_count_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic              commit;
    logic [DATA_W-1:0] write_data;

    assign write_data = memtoreg_q ? memdata_q : alu_q;

    // A stalled instruction stays in WB and commits once, on the edge where
    // stall drops. Writes to r0 are dropped and not counted.
    assign commit = regwrite_q && !stall && (wreg_q != '0);

    // MEM/WB next state: flush beats stall beats capture. The outgoing
    // instruction still commits on a flush edge because commit looks only
    // at the current WB contents.
    always_comb begin
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        wreg_d     = wreg_q;
        alu_d      = alu_q;
        memdata_d  = memdata_q;
        if (flush) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            wreg_d     = '0;
            alu_d      = '0;
            memdata_d  = '0;
        end else if (!stall) begin
            regwrite_d = RegWriteIn;
            memtoreg_d = MemtoRegIn;
            wreg_d     = WriteRegisterIn;
            alu_d      = ALUResultIn;
            memdata_d  = MemDataIn;
        end
    end

    // Register file and commit counter next state.
    always_comb begin
        regs_d         = regs_q;
        commit_count_d = commit_count_q;
        if (commit) begin
            regs_d[wreg_q] = write_data;
            commit_count_d = commit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            wreg_q         <= '0;
            alu_q          <= '0;
            memdata_q      <= '0;
            commit_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            wreg_q         <= wreg_d;
            alu_q          <= alu_d;
            memdata_q      <= memdata_d;
            commit_count_q <= commit_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads of r0 are forced to zero regardless of array contents.
    always_comb begin
        ReadData1 = (rs == '0) ? '0 : regs_q[rs];
        ReadData2 = (rt == '0) ? '0 : regs_q[rt];
`ifdef WB_INTERNAL_BYPASS_EN
        if (commit && (wreg_q == rs)) ReadData1 = write_data;
        if (commit && (wreg_q == rt)) ReadData2 = write_data;
`endif
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = write_data;
    assign CommitCount   = commit_count_q;

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Writer end of the writeback hazard path: the MEM/WB pipeline register, the writeback data mux and the 32-entry register file write port.
- Drives WriteRegister, WriteData and RegWrite to the WB forwarding logic.
- Provides the two raw register-file read ports (ReadData1/ReadData2) that the forwarding logic bypasses.
- Sits between the MEM stage outputs and the ID-stage operand read.

Parameters:
DATA_W, 32, register/data width in bits
ADDR_W, 5, register index width; register file depth = 2**ADDR_W

Ports:
clk  input  1  single clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
stall  input  1  hold MEM/WB contents, suppress commit
flush  input  1  load a bubble into MEM/WB
RegWriteIn  input  1  MEM-stage register write enable
MemtoRegIn  input  1  1: write memory data, 0: write ALU result
WriteRegisterIn  input  ADDR_W  MEM-stage destination register
ALUResultIn  input  DATA_W  MEM-stage ALU result
MemDataIn  input  DATA_W  MEM-stage load data
rs  input  ADDR_W  read address port 1
rt  input  ADDR_W  read address port 2
RegWrite  output  1  WB-stage write enable (registered)
WriteRegister  output  ADDR_W  WB-stage destination (registered)
WriteData  output  DATA_W  WB-stage write data (mux of registered fields)
ReadData1  output  DATA_W  register file read, port 1 (combinational)
ReadData2  output  DATA_W  register file read, port 2 (combinational)
CommitCount  output  32  number of register-file writes committed

Behaviour:
- Reset is synchronous, active-low. At the first rising clk with reset_n=0:
  - All MEM/WB fields are cleared, so RegWrite=0, WriteRegister=0, WriteData=0.
  - All register file entries are cleared to 0.
  - CommitCount is cleared to 0.
  - Reset overrides stall, flush and any pending commit.
  - Reset mid-operation discards the in-flight WB instruction without writing it.
- MEM/WB register update at each rising edge with reset_n=1, in priority order flush > stall > capture:
  - flush=1: bubble. RegWrite=0, MemtoReg=0, WriteRegister=0, ALUResult=0, MemData=0.
  - stall=1, flush=0: all fields hold.
  - Otherwise: capture all MEM-stage inputs.
- WriteData = MemtoReg_q ? MemData_q : ALUResult_q. Purely combinational from registered fields; no added latency.
- Latency: MEM inputs appear on the WB outputs one cycle after capture.
- Commit is the register-file write at the rising edge where all of the following hold:
  - reset_n=1
  - stall=0
  - RegWrite=1
  - WriteRegister≠0
- On commit: regs[WriteRegister] <= WriteData, and CommitCount increments by 1, wrapping 0xFFFFFFFF→0.
- A stalled WB instruction commits exactly once, at the edge where stall deasserts.
- flush together with a committing instruction: the current WB instruction still commits (stall=0) and the bubble replaces it.
- Register 0:
  - Never written.
  - Reads of address 0 always return 0.
  - A RegWrite targeting 0 does not increment CommitCount.
- Reads are asynchronous from register file contents. A read of the register being committed returns the OLD value until the edge; external WB forwarding covers this window (default build).
- Width rules:
  - All data paths are DATA_W bits, with no sign or zero extension inside the block.
  - Indices are ADDR_W bits; depth is exactly 2**ADDR_W.

Optional Feature:
Macro: WB_INTERNAL_BYPASS_EN
- Defined: write-first register file. When RegWrite=1, stall=0, WriteRegister≠0 and WriteRegister==rs (or rt), ReadData1 (or ReadData2) = WriteData combinationally. External WB forwarding becomes redundant but remains harmless.
- Undefined: reads return stored contents only; old value is returned until the commit edge.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with RegWriteIn=1, WriteRegisterIn=5 -> RegWrite=0, WriteData=0, CommitCount=0, ReadData1 (rs=5)=0.
- Basic write: capture RegWriteIn=1, WriteRegisterIn=7, ALUResultIn=0x1234, MemtoRegIn=0 -> next cycle WriteData=0x1234; one cycle later rs=7 reads 0x1234 and CommitCount=1.
- Load path and r0: MemtoRegIn=1, MemDataIn=0xDEADBEEF to r3, then a write of 0xFFFF to r0 -> r3=0xDEADBEEF; r0 reads 0; CommitCount increments only once.
- Stall: WB holds a write of 0xAA to r9, stall=1 for 3 cycles -> outputs stable, r9 unchanged, no count; stall=0 -> exactly one commit, count+1.
- Flush: capture a write to r4, flush=1 on the next edge -> r4 written once by the outgoing instruction, then RegWrite=0 and WriteRegister=0; no further writes.
- Same-cycle read: commit of 0x55 to r6 with rs=6 -> without macro, ReadData1=old value (0); with WB_INTERNAL_BYPASS_EN, ReadData1=0x55 in the same cycle.
